// File: rtl/bus_control_pipe.sv
// Multi-channel bus select pipeline: DEPTH register stages of raw select codes,
// one-hot decoded from the last stage. Optional checker under BUSCTRL_ERRCHK_EN.
module bus_control_pipe #(
  parameter int SEL_W  = 4,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1
) (
  input  logic                          Clock_In,
  input  logic                          Reset_In,
  input  logic [NUM_CH*SEL_W-1:0]       Assert_Sel,
  input  logic [NUM_CH*SEL_W-1:0]       Load_Sel,
  input  logic                          Stall_In,
  input  logic                          Flush_In,
  output logic [NUM_CH*(2**SEL_W)-1:0]  Assert_En,
  output logic [NUM_CH*(2**SEL_W)-1:0]  Load_En,
  output logic                          Busy,
  output logic                          Err_Flag,
  output logic [7:0]                    Err_Count
);

  localparam int DEC_W  = 2**SEL_W;
  localparam int CODE_W = NUM_CH*SEL_W;

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("bus_control_pipe: DEPTH must be 1..4");
  end

  logic [CODE_W-1:0] a_q [DEPTH];
  logic [CODE_W-1:0] l_q [DEPTH];
  logic [SEL_W-1:0]  a_code;
  logic [SEL_W-1:0]  l_code;

  // Flush wins over stall; stall freezes every stage.
  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        l_q[i] <= '0;
      end
    end else if (Flush_In) begin
      for (int i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        l_q[i] <= '0;
      end
    end else if (!Stall_In) begin
      a_q[0] <= Assert_Sel;
      l_q[0] <= Load_Sel;
      for (int i = 1; i < DEPTH; i++) begin
        a_q[i] <= a_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  // Outputs depend only on the final stage register, never on the inputs.
  always_comb begin
    Assert_En = '0;
    Load_En   = '0;
    a_code    = '0;
    l_code    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      a_code = a_q[DEPTH-1][c*SEL_W +: SEL_W];
      l_code = l_q[DEPTH-1][c*SEL_W +: SEL_W];
      if (a_code != '0) Assert_En[c*DEC_W + int'(a_code)] = 1'b1;
      if (l_code != '0) Load_En[c*DEC_W + int'(l_code)] = 1'b1;
    end
  end

  always_comb begin
    Busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_q[i] != '0 || l_q[i] != '0) Busy = 1'b1;
    end
  end

`ifdef BUSCTRL_ERRCHK_EN
  logic err_now;

  // A load with no driver on any channel of the final stage.
  always_comb begin
    err_now = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (l_q[DEPTH-1][c*SEL_W +: SEL_W] != '0 &&
          a_q[DEPTH-1][c*SEL_W +: SEL_W] == '0) err_now = 1'b1;
    end
  end

  always_ff @(posedge Clock_In or negedge Reset_In) begin
    if (!Reset_In) begin
      Err_Flag  <= 1'b0;
      Err_Count <= 8'd0;
    end else if (err_now && !Stall_In) begin
      Err_Flag <= 1'b1;
      if (Err_Count != 8'hFF) Err_Count <= Err_Count + 8'd1;
    end
  end
`else
  assign Err_Flag  = 1'b0;
  assign Err_Count = 8'd0;
`endif

endmodule

// File: tb/tb_bus_control_pipe.sv
// Bench for bus_control_pipe: three instances (DEPTH 1..3) share stimulus and are
// compared every cycle against a shift-register reference model.
module tb_bus_control_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  asel, lsel;
  logic        stall, flush;

  logic [31:0] ae [3];
  logic [31:0] le [3];
  logic        busy [3];
  logic        eflag [3];
  logic [7:0]  ecount [3];

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [7:0]  ma [3][4];
  logic [7:0]  ml [3][4];
  int          mcount [3];
  logic        mflag [3];

  always #5 clk = ~clk;

  for (genvar d = 0; d < 3; d++) begin : g_dut
    bus_control_pipe #(.SEL_W(4), .NUM_CH(2), .DEPTH(d+1)) u_dut (
      .Clock_In  (clk),
      .Reset_In  (rst_n),
      .Assert_Sel(asel),
      .Load_Sel  (lsel),
      .Stall_In  (stall),
      .Flush_In  (flush),
      .Assert_En (ae[d]),
      .Load_En   (le[d]),
      .Busy      (busy[d]),
      .Err_Flag  (eflag[d]),
      .Err_Count (ecount[d])
    );
  end

  function automatic logic [31:0] onehot(input logic [7:0] codes);
    logic [31:0] r = '0;
    for (int c = 0; c < 2; c++) begin
      int n = int'(codes[c*4 +: 4]);
      if (n != 0) r = r | (32'd1 << (c*16 + n));
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        ma[d][i] = '0;
        ml[d][i] = '0;
      end
      mcount[d] = 0;
      mflag[d]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int  last = d;
      bit  e = 0;
      for (int c = 0; c < 2; c++) begin
        if (ml[d][last][c*4 +: 4] != 0 && ma[d][last][c*4 +: 4] == 0) e = 1;
      end
      if (e && !stall) begin
        mflag[d] = 1'b1;
        if (mcount[d] < 255) mcount[d]++;
      end
      if (flush) begin
        for (int i = 0; i <= last; i++) begin
          ma[d][i] = '0;
          ml[d][i] = '0;
        end
      end else if (!stall) begin
        for (int i = last; i >= 1; i--) begin
          ma[d][i] = ma[d][i-1];
          ml[d][i] = ml[d][i-1];
        end
        ma[d][0] = asel;
        ml[d][0] = lsel;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 3; d++) begin
      logic b = 1'b0;
      for (int i = 0; i <= d; i++) if (ma[d][i] != 0 || ml[d][i] != 0) b = 1'b1;
      chk($sformatf("%s d%0d assert_en", tag, d+1), ae[d], onehot(ma[d][d]));
      chk($sformatf("%s d%0d load_en", tag, d+1), le[d], onehot(ml[d][d]));
      chk($sformatf("%s d%0d busy", tag, d+1), 32'(busy[d]), 32'(b));
`ifdef BUSCTRL_ERRCHK_EN
      chk($sformatf("%s d%0d err_flag", tag, d+1), 32'(eflag[d]), 32'(mflag[d]));
      chk($sformatf("%s d%0d err_count", tag, d+1), 32'(ecount[d]), 32'(mcount[d]));
`else
      chk($sformatf("%s d%0d err_flag", tag, d+1), 32'(eflag[d]), 32'd0);
      chk($sformatf("%s d%0d err_count", tag, d+1), 32'(ecount[d]), 32'd0);
`endif
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    asel = '0; lsel = '0; stall = 1'b0; flush = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // sweep every code on both channels
    for (int n = 0; n < 16; n++) begin
      asel = {4'(15 - n), 4'(n)};
      lsel = {4'(n), 4'(n)};
      step("sweep");
    end
    asel = '0; lsel = '0;
    for (int i = 0; i < 3; i++) step("drain");

    // single-cycle pulse of code 5 on channel 0
    asel = 8'h05;
    step("pulse");
    asel = '0;
    for (int i = 0; i < 4; i++) step("pulse_tail");

    // hold under stall, then new code follows in order
    asel = 8'h07; lsel = 8'h07;
    step("stall_load");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step("stall_hold");
    stall = 1'b0; asel = 8'h03; lsel = 8'h30;
    for (int i = 0; i < 3; i++) step("stall_release");

    // flush beats stall with codes in flight
    asel = 8'h9A; lsel = 8'h9A;
    step("flush_fill");
    asel = 8'h21; lsel = 8'h12;
    step("flush_fill2");
    stall = 1'b1; flush = 1'b1;
    step("flush");
    stall = 1'b0; flush = 1'b0; asel = '0; lsel = '0;
    step("post_flush");

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      asel  = 8'($urandom);
      lsel  = 8'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step("random");
    end
    stall = 1'b0; flush = 1'b0;

    // load with no driver long enough to saturate the error counter
    asel = 8'h00; lsel = 8'h04;
    for (int i = 0; i < 300; i++) step("err_sat");
    asel = 8'h56; lsel = 8'h56;
    for (int i = 0; i < 5; i++) step("err_hold");

    // asynchronous reset mid-cycle
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    #2;
    rst_n = 1'b1;
    asel = 8'h3C; lsel = 8'hC3;
    for (int i = 0; i < 4; i++) step("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_control_pipe.md
BUS_CONTROL_PIPE -- requirements
Module: bus_control_pipe

Interface
REQ-001 Parameter SEL_W, default 4, width of each bus select code; decoded width is 2**SEL_W, and code 0 means "no device".
REQ-002 Parameter NUM_CH, default 2, number of independent bus channels (main, transfer, ...).
REQ-003 Parameter DEPTH, default 1, number of decode register stages between select inputs and enable outputs; legal range 1..4.
REQ-004 Port Clock_In, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port Reset_In, input, 1, asynchronous active-low reset.
REQ-006 Port Assert_Sel, input, NUM_CH*SEL_W, per-channel driver select code; channel c occupies bits [c*SEL_W +: SEL_W].
REQ-007 Port Load_Sel, input, NUM_CH*SEL_W, per-channel load select code; packed the same way as Assert_Sel.
REQ-008 Port Stall_In, input, 1, active-high hold of the whole pipeline.
REQ-009 Port Flush_In, input, 1, active-high synchronous clear of the whole pipeline to idle.
REQ-010 Port Assert_En, output, NUM_CH*2**SEL_W, registered one-hot driver enables; bit 0 of each channel is always 0.
REQ-011 Port Load_En, output, NUM_CH*2**SEL_W, registered one-hot load enables; bit 0 of each channel is always 0.
REQ-012 Port Busy, output, 1, high when any stage holds a non-zero code.
REQ-013 Port Err_Flag, output, 1, sticky protocol-error flag.
REQ-014 Port Err_Count, output, 8, saturating protocol-error count.

Function
REQ-015 The pipeline is DEPTH stages deep; each stage holds the raw Assert_Sel/Load_Sel codes for all channels, and outputs are decoded from the final stage.
- Decode is registered; no combinational path runs from any input to Assert_En/Load_En.
REQ-016 Latency: with Stall_In=0 and Flush_In=0, a code presented before edge k appears on the outputs after edge k+DEPTH-1 (DEPTH=1: visible one edge after presentation).
REQ-017 Decode: for each channel, code n != 0 drives bit n high and all other bits of that channel low; code 0 drives all bits of that channel low.
REQ-018 Stall_In=1: all stages and outputs hold their values; inputs are ignored.
REQ-019 Flush_In=1: all stages load code 0 on the next edge, and all enables are 0 after that edge.
- Flush_In takes priority over Stall_In.
REQ-020 Busy is the OR of all non-zero stage codes across all stages and channels, and is registered with the stages.
REQ-021 Channels are independent; identical codes on different channels are legal and are not an error.
REQ-022 Simultaneous equal non-zero Assert and Load codes within one channel are legal (self-load) and are decoded as given.

Reset
REQ-023 Reset_In low asynchronously clears all stages, Assert_En, Load_En, Busy, Err_Flag and Err_Count to 0.
REQ-024 Reset asserted mid-pipeline discards all in-flight codes; the first edge after release captures inputs normally.

Configuration
REQ-025 Macro BUSCTRL_ERRCHK_EN.
- Defined: a protocol error is a channel whose final-stage Load code is non-zero while its final-stage Assert code is 0 (load with no driver).
- Defined: each edge with at least one such channel and Stall_In=0 increments Err_Count by 1, saturating at 255, and sets Err_Flag; Err_Flag and Err_Count clear only on reset.
- Not defined: Err_Flag and Err_Count are tied to 0 and no checking logic exists.

Verification
REQ-026 DEPTH=1, SEL_W=4, NUM_CH=2: sweep codes 0..15 on both channels -> after one edge exactly bit n of each channel is high; code 0 gives all-zero.
REQ-027 DEPTH=3: apply ch0 Assert=5 for one cycle, then 0 -> Assert_En bit 5 high for exactly one cycle, starting three edges later; Busy high for three cycles.
REQ-028 DEPTH=2: apply code 7, raise Stall_In for 4 cycles, then change the input to 3 -> outputs hold for 4 cycles, then 7 then 3 emerge in order.
REQ-029 DEPTH=2: raise Flush_In and Stall_In together with codes in flight -> all enables 0 and Busy 0 after one edge.
REQ-030 With BUSCTRL_ERRCHK_EN: hold Load=4, Assert=0 for 300 cycles -> Err_Flag=1 and Err_Count=255; then apply legal codes -> values hold; then pulse Reset_In low mid-cycle -> all outputs 0 immediately, with no clock edge needed.
